// File: rtl/output_manager_if.sv
`default_nettype none
// ============================================================================
// Module      : output_manager_if
// Description : Bundle between the score RAM / sequencing side and the
//               output_manager staging bank.
//               master : drives en_read, count, ram_data and signal, and
//                        receives the committed diag/up/left scores.
//               slave  : the output_manager side of the same signals.
// Parameters  : DATA_W - width of RAM words and score outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface output_manager_if #(
    parameter int DATA_W = 9
);
    logic              en_read;   // capture enable
    logic [1:0]        count;     // 0 = diag, 1 = up, 2 = left, 3 = no capture
    logic [DATA_W-1:0] ram_data;  // score RAM read word
    logic              signal;    // commit strobe
    logic [DATA_W-1:0] diag;      // committed diagonal-neighbour score
    logic [DATA_W-1:0] up;        // committed upper-neighbour score
    logic [DATA_W-1:0] left;      // committed left-neighbour score

    modport master (
        output en_read, count, ram_data, signal,
        input  diag, up, left
    );

    modport slave (
        input  en_read, count, ram_data, signal,
        output diag, up, left
    );
endinterface
`default_nettype wire

// File: rtl/output_manager.sv
`default_nettype none
// ============================================================================
// Module      : output_manager
// Description : Staging and commit register bank between the score RAM read
//               port and the cell-computation datapath. Three sequential RAM
//               words (diag, up, left) are captured into staging registers
//               selected by count; a commit strobe copies the whole staged
//               triple to the registered outputs in one edge, so downstream
//               logic always sees a consistent neighbour triple.
// Ports       : clk  - single clock, rising edge
//               rst  - synchronous, active-high reset
//               bus  - output_manager_if.slave (en_read, count, ram_data,
//                      signal in; diag, up, left out)
// Parameters  : DATA_W - width of RAM words and score outputs.
// Options     : OUTPUT_MANAGER_AUTOCOMMIT_EN - when defined, capturing the
//               left word (en_read=1, count=2) also commits at the same edge,
//               with the incoming word routed straight to the left output.
// Revision    : 1.0 - initial release
// ============================================================================
module output_manager #(
    parameter int DATA_W = 9
) (
    input  wire logic          clk,
    input  wire logic          rst,
    output_manager_if.slave    bus
);

    localparam logic [1:0] c_IDX_DIAG = 2'd0;
    localparam logic [1:0] c_IDX_UP   = 2'd1;
    localparam logic [1:0] c_IDX_LEFT = 2'd2;

    logic [DATA_W-1:0] r_diag_s;
    logic [DATA_W-1:0] r_up_s;
    logic [DATA_W-1:0] r_left_s;
    logic [DATA_W-1:0] r_diag;
    logic [DATA_W-1:0] r_up;
    logic [DATA_W-1:0] r_left;

    logic              w_commit;
    logic [DATA_W-1:0] w_left_next;

`ifdef OUTPUT_MANAGER_AUTOCOMMIT_EN
    logic w_auto;

    // The left word is the last of the triple, so its capture completes the
    // set; bypass staging for it so the triple lands one edge after the read.
    assign w_auto      = bus.en_read && (bus.count == c_IDX_LEFT);
    assign w_commit    = bus.signal || w_auto;
    assign w_left_next = w_auto ? bus.ram_data : r_left_s;
`else
    assign w_commit    = bus.signal;
    assign w_left_next = r_left_s;
`endif

    // Staging capture. Index 3 is a deliberate "no capture" slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_diag_s <= '0;
            r_up_s   <= '0;
            r_left_s <= '0;
        end else if (bus.en_read) begin
            case (bus.count)
                c_IDX_DIAG: r_diag_s <= bus.ram_data;
                c_IDX_UP:   r_up_s   <= bus.ram_data;
                c_IDX_LEFT: r_left_s <= bus.ram_data;
                default:    ;
            endcase
        end
    end

    // Commit reads the staging values held before this edge, so a word
    // captured in the same cycle only reaches the outputs at the next commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_diag <= '0;
            r_up   <= '0;
            r_left <= '0;
        end else if (w_commit) begin
            r_diag <= r_diag_s;
            r_up   <= r_up_s;
            r_left <= w_left_next;
        end
    end

    assign bus.diag = r_diag;
    assign bus.up   = r_up;
    assign bus.left = r_left;

endmodule
`default_nettype wire

// File: tb/tb_output_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_manager
// Description : Self-checking bench for output_manager. A table of directed
//               vectors covers reset, triples, gating and same-edge
//               capture/commit; randomized traffic is then compared against a
//               behavioural model of the staging/commit rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_manager;

    localparam int DATA_W = 9;

    typedef struct {
        logic              rst;
        logic              en_read;
        logic [1:0]        count;
        logic [DATA_W-1:0] ram_data;
        logic              signal;
        logic [DATA_W-1:0] exp_diag;
        logic [DATA_W-1:0] exp_up;
        logic [DATA_W-1:0] exp_left;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    output_manager_if #(.DATA_W(DATA_W)) bus ();

    output_manager #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the staged triple and the committed triple as arrays.
    logic [DATA_W-1:0] m_stage [3];
    logic [DATA_W-1:0] m_out   [3];

    task automatic model_edge(input logic r, input logic en, input logic [1:0] cnt,
                              input logic [DATA_W-1:0] d, input logic sig);
        logic [DATA_W-1:0] old [3];
        old = m_stage;
        if (r) begin
            for (int k = 0; k < 3; k++) begin
                m_stage[k] = '0;
                m_out[k]   = '0;
            end
        end else begin
            if (en && cnt != 2'd3) m_stage[cnt] = d;
            if (sig) m_out = old;
`ifdef OUTPUT_MANAGER_AUTOCOMMIT_EN
            if (en && cnt == 2'd2) begin
                m_out[0] = old[0];
                m_out[1] = old[1];
                m_out[2] = d;
            end
`endif
        end
    endtask

    // Drive on the falling edge, let the rising edge happen, sample 1 ns later.
    task automatic step(input logic r, input logic en, input logic [1:0] cnt,
                        input logic [DATA_W-1:0] d, input logic sig);
        @(negedge clk);
        rst          = r;
        bus.en_read  = en;
        bus.count    = cnt;
        bus.ram_data = d;
        bus.signal   = sig;
        @(posedge clk);
        #1;
        model_edge(r, en, cnt, d, sig);
    endtask

    task automatic check(input string name, input logic [DATA_W-1:0] ed,
                         input logic [DATA_W-1:0] eu, input logic [DATA_W-1:0] el);
        total++;
        if (bus.diag !== ed || bus.up !== eu || bus.left !== el) begin
            bad++;
            $display("FAIL %s: got diag=%0d up=%0d left=%0d, want diag=%0d up=%0d left=%0d",
                     name, bus.diag, bus.up, bus.left, ed, eu, el);
        end
    endtask

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        bus.en_read  = 1'b0;
        bus.count    = 2'd0;
        bus.ram_data = '0;
        bus.signal   = 1'b0;

`ifndef OUTPUT_MANAGER_AUTOCOMMIT_EN
        //            rst  en   cnt   data    sig   diag up   left
        vecs.push_back('{1'b1, 1'b1, 2'd0, 9'd9,   1'b1, 9'd0,  9'd0, 9'd0});
        vecs.push_back('{1'b1, 1'b1, 2'd1, 9'd9,   1'b1, 9'd0,  9'd0, 9'd0});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 9'd0,   1'b1, 9'd0,  9'd0, 9'd0});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 9'd9,   1'b0, 9'd0,  9'd0, 9'd0});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 9'd8,   1'b0, 9'd0,  9'd0, 9'd0});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 9'd7,   1'b0, 9'd0,  9'd0, 9'd0});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 9'd0,   1'b1, 9'd9,  9'd8, 9'd7});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 9'd6,   1'b0, 9'd9,  9'd8, 9'd7});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 9'd5,   1'b0, 9'd9,  9'd8, 9'd7});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 9'd4,   1'b0, 9'd9,  9'd8, 9'd7});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 9'd0,   1'b1, 9'd6,  9'd5, 9'd4});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 9'd3,   1'b0, 9'd6,  9'd5, 9'd4});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 9'd2,   1'b0, 9'd6,  9'd5, 9'd4});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 9'd1,   1'b0, 9'd6,  9'd5, 9'd4});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 9'd0,   1'b1, 9'd3,  9'd2, 9'd1});
        vecs.push_back('{1'b0, 1'b0, 2'd1, 9'd100, 1'b0, 9'd3,  9'd2, 9'd1});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 9'd0,   1'b1, 9'd3,  9'd2, 9'd1});
        vecs.push_back('{1'b0, 1'b1, 2'd3, 9'd55,  1'b0, 9'd3,  9'd2, 9'd1});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 9'd0,   1'b1, 9'd3,  9'd2, 9'd1});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 9'd20,  1'b1, 9'd3,  9'd2, 9'd1});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 9'd0,   1'b1, 9'd20, 9'd2, 9'd1});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 9'h1FF, 1'b0, 9'd20, 9'd2, 9'd1});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 9'h155, 1'b0, 9'd20, 9'd2, 9'd1});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 9'd0,   1'b1, 9'd20, 9'd2, 9'h155});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 9'd11,  1'b0, 9'd20, 9'd2, 9'h155});
        vecs.push_back('{1'b1, 1'b1, 2'd0, 9'd12,  1'b1, 9'd0,  9'd0, 9'd0});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 9'd0,   1'b1, 9'd0,  9'd0, 9'd0});

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en_read, vecs[i].count,
                 vecs[i].ram_data, vecs[i].signal);
            check($sformatf("vec%0d", i), vecs[i].exp_diag, vecs[i].exp_up, vecs[i].exp_left);
        end
`else
        // Left capture alone completes the commit, one edge after the read.
        step(1'b1, 1'b1, 2'd0, 9'd9, 1'b1);
        check("auto_reset", 9'd0, 9'd0, 9'd0);
        step(1'b0, 1'b1, 2'd0, 9'd9, 1'b0);
        check("auto_diag_cap", 9'd0, 9'd0, 9'd0);
        step(1'b0, 1'b1, 2'd1, 9'd8, 1'b0);
        check("auto_up_cap", 9'd0, 9'd0, 9'd0);
        step(1'b0, 1'b1, 2'd2, 9'd7, 1'b0);
        check("auto_left_cap", 9'd9, 9'd8, 9'd7);
        step(1'b0, 1'b1, 2'd0, 9'd30, 1'b0);
        check("auto_hold", 9'd9, 9'd8, 9'd7);
        step(1'b0, 1'b0, 2'd0, 9'd0, 1'b1);
        check("auto_signal", 9'd30, 9'd8, 9'd7);
`endif

        // Randomized traffic against the model; start from a clean reset.
        step(1'b1, 1'b0, 2'd0, 9'd0, 1'b0);
        check("rand_reset", m_out[0], m_out[1], m_out[2]);
        for (int n = 0; n < 400; n++) begin
            logic              r;
            logic              en;
            logic [1:0]        cnt;
            logic [DATA_W-1:0] d;
            logic              sig;
            r   = ($urandom_range(0, 39) == 0);
            en  = ($urandom_range(0, 3) != 0);
            cnt = 2'($urandom_range(0, 3));
            d   = DATA_W'($urandom);
            sig = ($urandom_range(0, 3) == 0);
            step(r, en, cnt, d, sig);
            check($sformatf("rand%0d", n), m_out[0], m_out[1], m_out[2]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
